// File: rtl/game_control.sv
// Game-level controller: IDLE/RUN/OVER sequencing, single scrolling obstacle,
// dinosaur/obstacle collision and saturating score.
module game_control #(
  parameter int SCREEN_W    = 160,
  parameter int DINO_X      = 16,
  parameter int OBST_W      = 4,
  parameter int SPEED_DIV   = 2,
  parameter int CLEAR_LEVEL = 40
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        tick,
  input  logic        button_start,
  input  logic [5:0]  dinosaur_height,
  output logic        game_status,
  output logic [7:0]  obstacle_x,
  output logic        obstacle_valid,
  output logic [13:0] score,
  output logic        game_over
);

  localparam int          DIV_W     = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
  localparam logic [7:0]  SPAWN_X   = 8'(SCREEN_W - 1);
  localparam logic [7:0]  HIT_LO    = 8'(DINO_X);
  localparam logic [7:0]  HIT_HI    = 8'(DINO_X + OBST_W - 1);
  localparam logic [5:0]  CLEAR_H   = 6'(CLEAR_LEVEL);
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               status_q, over_q, over_d;
  logic               btn_prev_q;
  logic [7:0]         x_q, x_d;
  logic               valid_q, valid_d;
  logic [13:0]        score_q, score_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [4:0]         gap_q, gap_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               start_edge, hit;

  // A button held through reset sees prev=1 and therefore produces no edge.
  assign start_edge = button_start & ~btn_prev_q;

  assign hit = (state_q == ST_RUN) && valid_q &&
               (x_q >= HIT_LO) && (x_q <= HIT_HI) &&
               (dinosaur_height > CLEAR_H);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    valid_d = valid_q;
    score_d = score_q;
    div_d   = div_q;
    gap_d   = gap_q;
    over_d  = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d = ST_RUN;
          score_d = '0;
          x_d     = SPAWN_X;
          valid_d = 1'b1;
          div_d   = '0;
          gap_d   = '0;
        end
      end
      ST_RUN: begin
        // Collision outranks a coincident step: the step is simply dropped.
        if (hit) begin
          state_d = ST_OVER;
          over_d  = 1'b1;
        end else if (tick) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (valid_q) begin
              if (x_q != 8'd0) begin
                x_d = x_q - 8'd1;
              end else begin
                valid_d = 1'b0;
                score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 14'd1;
                gap_d   = 5'd8 + {1'b0, lfsr_q[3:0]};
              end
            end else if (gap_q == 5'd0) begin
              x_d     = SPAWN_X;
              valid_d = 1'b1;
            end else begin
              gap_d = gap_q - 5'd1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      status_q   <= 1'b0;
      over_q     <= 1'b0;
      btn_prev_q <= 1'b1;
      x_q        <= SPAWN_X;
      valid_q    <= 1'b0;
      score_q    <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      lfsr_q     <= 8'hA5;
    end else begin
      state_q    <= state_d;
      status_q   <= (state_d == ST_RUN);
      over_q     <= over_d;
      btn_prev_q <= button_start;
      x_q        <= x_d;
      valid_q    <= valid_d;
      score_q    <= score_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign game_status    = status_q;
  assign obstacle_x     = x_q;
  assign obstacle_valid = valid_q;
  assign score          = score_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: directed scenarios plus randomized play, all checked
// against a rule-level model of the game.
module tb_game_control;

  localparam int SCREEN_W    = 160;
  localparam int DINO_X      = 16;
  localparam int OBST_W      = 4;
  localparam int SPEED_DIV   = 2;
  localparam int CLEAR_LEVEL = 40;
  localparam int SCORE_MAX   = 9999;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        tick = 1'b0;
  logic        button_start = 1'b0;
  logic [5:0]  dinosaur_height = 6'd63;
  logic        game_status;
  logic [7:0]  obstacle_x;
  logic        obstacle_valid;
  logic [13:0] score;
  logic        game_over;

  game_control #(
    .SCREEN_W(SCREEN_W), .DINO_X(DINO_X), .OBST_W(OBST_W),
    .SPEED_DIV(SPEED_DIV), .CLEAR_LEVEL(CLEAR_LEVEL)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .tick(tick), .button_start(button_start),
    .dinosaur_height(dinosaur_height), .game_status(game_status),
    .obstacle_x(obstacle_x), .obstacle_valid(obstacle_valid),
    .score(score), .game_over(game_over)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: game rules in terms of tick counts and steps left
  typedef enum {M_IDLE, M_RUN, M_OVER} mstate_t;
  mstate_t    m_state = M_IDLE;
  int         m_x = SCREEN_W - 1;
  int         m_score = 0;
  int         m_ticks = 0;
  int         m_gap_left = 0;
  bit         m_valid = 1'b0;
  bit         m_over = 1'b0;
  bit         m_prev = 1'b1;
  logic [7:0] m_lfsr = 8'hA5;

  task automatic model_clock(input bit rst_n, input bit tk, input bit btn, input int h);
    bit start_edge, hit;
    if (!rst_n) begin
      m_state = M_IDLE; m_x = SCREEN_W - 1; m_valid = 1'b0; m_score = 0;
      m_over = 1'b0; m_prev = 1'b1; m_lfsr = 8'hA5; m_ticks = 0; m_gap_left = 0;
      return;
    end
    start_edge = btn && !m_prev;
    m_prev = btn;
    hit = (m_state == M_RUN) && m_valid && (m_x >= DINO_X) &&
          (m_x < DINO_X + OBST_W) && (h > CLEAR_LEVEL);
    m_over = hit;
    if (m_state != M_RUN) begin
      if (start_edge) begin
        m_state = M_RUN; m_score = 0; m_x = SCREEN_W - 1; m_valid = 1'b1;
        m_ticks = 0; m_gap_left = 0;
      end
    end else if (hit) begin
      m_state = M_OVER;
    end else if (tk) begin
      m_ticks++;
      if (m_ticks % SPEED_DIV == 0) begin
        if (m_valid) begin
          if (m_x > 0) m_x--;
          else begin
            m_valid = 1'b0;
            m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
            m_gap_left = 9 + int'(m_lfsr[3:0]);
          end
        end else begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_x = SCREEN_W - 1;
            m_valid = 1'b1;
          end
        end
      end
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  // driver: one clock with the given inputs, then compare every output
  task automatic cycle(input bit rst_n, input bit tk, input bit btn, input int h);
    RST_N = rst_n;
    tick = tk;
    button_start = btn;
    dinosaur_height = 6'(h);
    @(posedge CLK);
    model_clock(rst_n, tk, btn, h);
    @(negedge CLK);
    check_eq("game_status", game_status, (m_state == M_RUN));
    check_eq("obstacle_x", obstacle_x, m_x);
    check_eq("obstacle_valid", obstacle_valid, m_valid);
    check_eq("score", score, m_score);
    check_eq("game_over", game_over, m_over);
  endtask

  initial begin
    int waited;
    int guard;

    // reset, then idle with the button low
    repeat (3) cycle(0, 0, 0, 63);
    check_eq("rst_status", game_status, 0);
    check_eq("rst_x", obstacle_x, 159);
    check_eq("rst_valid", obstacle_valid, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_over", game_over, 0);
    repeat (50) cycle(1, 1, 0, 63);
    check_eq("idle_status", game_status, 0);
    check_eq("idle_x", obstacle_x, 159);
    check_eq("idle_valid", obstacle_valid, 0);
    check_eq("idle_score", score, 0);

    // start on the ground and run into the obstacle
    cycle(1, 0, 1, 63);
    check_eq("start_status", game_status, 1);
    check_eq("start_valid", obstacle_valid, 1);
    repeat (280) cycle(1, 1, 0, 63);
    check_eq("x_after_280", obstacle_x, 19);
    check_eq("no_over_yet", game_over, 0);
    cycle(1, 1, 0, 63);
    check_eq("over_pulse", game_over, 1);
    check_eq("over_status", game_status, 0);
    check_eq("over_x_frozen", obstacle_x, 19);
    cycle(1, 1, 0, 63);
    check_eq("over_pulse_end", game_over, 0);
    check_eq("over_x_still", obstacle_x, 19);

    // collision and step in the same cycle: step is discarded
    cycle(1, 0, 1, 10);
    check_eq("restart_x", obstacle_x, 159);
    repeat (284) cycle(1, 1, 0, 10);
    check_eq("x_at_17", obstacle_x, 17);
    cycle(1, 1, 0, 10);
    cycle(1, 1, 0, 63);
    check_eq("coll_step_x", obstacle_x, 17);
    check_eq("coll_step_over", game_over, 1);
    check_eq("coll_step_status", game_status, 0);

    // jump over the obstacle, then wait for respawn
    cycle(1, 0, 1, 10);
    repeat (320) cycle(1, 1, 0, 10);
    check_eq("pass_valid", obstacle_valid, 0);
    check_eq("pass_score", score, 1);
    waited = 0;
    while (!obstacle_valid && waited < 60) begin
      cycle(1, 1, 0, 10);
      waited++;
    end
    check_eq("respawn_valid", obstacle_valid, 1);
    check_eq("respawn_x", obstacle_x, 159);
    check_eq("respawn_gap_ok", (waited >= 18 && waited <= 48 && waited % 2 == 0), 1);

    // reach score 3, crash, restart from OVER
    guard = 0;
    while (m_score < 3 && guard < 2000) begin
      cycle(1, 1, 0, 10);
      guard++;
    end
    check_eq("score_3", score, 3);
    guard = 0;
    while (!m_over && guard < 1000) begin
      cycle(1, 1, 0, 63);
      guard++;
    end
    check_eq("crash_over", game_over, 1);
    check_eq("crash_score", score, 3);
    cycle(1, 0, 1, 63);
    check_eq("restart_score", score, 0);
    check_eq("restart_x2", obstacle_x, 159);
    check_eq("restart_status", game_status, 1);

    // reset mid-run with the button held, release: no start
    repeat (4) cycle(1, 1, 0, 63);
    cycle(0, 0, 1, 63);
    check_eq("midrst_status", game_status, 0);
    check_eq("midrst_x", obstacle_x, 159);
    check_eq("midrst_valid", obstacle_valid, 0);
    check_eq("midrst_score", score, 0);
    check_eq("midrst_over", game_over, 0);
    cycle(0, 0, 1, 63);
    repeat (3) cycle(1, 0, 1, 63);
    repeat (3) cycle(1, 1, 0, 63);
    check_eq("held_btn_no_start", game_status, 0);

    // score saturation
    cycle(1, 0, 1, 10);
    force dut.score_q = 14'd9998;
    m_score = 9998;
    cycle(1, 0, 0, 10);
    release dut.score_q;
    guard = 0;
    while (m_score < SCORE_MAX && guard < 1000) begin
      cycle(1, 1, 0, 10);
      guard++;
    end
    check_eq("score_9999", score, 9999);
    repeat (800) cycle(1, 1, 0, 10);
    check_eq("score_sat", score, 9999);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      bit r, tk, b;
      int h;
      r  = ($urandom_range(0, 199) != 0);
      tk = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       h = 63;
        1:       h = 10;
        2:       h = $urandom_range(0, 63);
        default: h = $urandom_range(39, 42);
      endcase
      cycle(r, tk, b, h);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
